// File: rtl/simd_pkg.sv
// Shared encodings, state enum and capture record for the SIMD lane drain.
package simd_pkg;

  localparam logic [1:0] W8   = 2'b00;
  localparam logic [1:0] W16  = 2'b01;
  localparam logic [1:0] W32  = 2'b10;
  localparam logic [1:0] WRSV = 2'b11;

  typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;

  typedef struct packed {
    logic [31:0] result;
    logic [1:0]  width;
    logic        saturate;
    logic [3:0]  overflow;
`ifdef SIMD_DRAIN_CARRY_EN
    logic [3:0]  carry;
`endif
  } cap_t;

  function automatic logic [2:0] lane_count(input logic [1:0] w);
    case (w)
      W8:      lane_count = 3'd4;
      W16:     lane_count = 3'd2;
      default: lane_count = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/simd_lane_mux.sv
// Combinational lane selector: picks one lane of the captured result, extends it,
// and selects the matching per-slice flags. Carry path exists only with SIMD_DRAIN_CARRY_EN.
module simd_lane_mux
  import simd_pkg::*;
#(
  parameter int SIGN_EXT = 1
) (
  input  logic [31:0] result,
  input  logic [3:0]  overflow,
  input  logic [1:0]  width,
  input  logic [1:0]  lane,
  output logic [31:0] lane_data,
  output logic        lane_ovf,
  output logic        lane_last
`ifdef SIMD_DRAIN_CARRY_EN
  ,
  input  logic [3:0]  carry,
  output logic        lane_carry
`endif
);

  logic [7:0]  b8;
  logic [15:0] h16;
  logic [1:0]  sel;

  always_comb begin
    b8        = result[{lane, 3'b000} +: 8];
    h16       = lane[0] ? result[31:16] : result[15:0];
    lane_data = result;
    sel       = 2'd3;
    case (width)
      W8: begin
        sel       = lane;
        lane_data = (SIGN_EXT != 0) ? {{24{b8[7]}}, b8} : {24'h0, b8};
      end
      W16: begin
        // 16-bit lanes report the flag of their upper byte slice
        sel       = {lane[0], 1'b1};
        lane_data = (SIGN_EXT != 0) ? {{16{h16[15]}}, h16} : {16'h0, h16};
      end
      default: ;
    endcase
    lane_ovf  = overflow[sel];
    lane_last = ({1'b0, lane} == (lane_count(width) - 3'd1));
  end

`ifdef SIMD_DRAIN_CARRY_EN
  assign lane_carry = carry[sel];
`endif

endmodule

// File: rtl/simd_lane_drain.sv
// Captures one packed SIMD result and streams it out lane by lane with a
// sticky saturation-event counter. Optional out_carry under SIMD_DRAIN_CARRY_EN.
module simd_lane_drain
  import simd_pkg::*;
#(
  parameter int SIGN_EXT = 1,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      result,
  input  logic [1:0]       width,
  input  logic             saturate,
  input  logic [3:0]       overflow,
  input  logic [3:0]       carry_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [1:0]       out_lane,
  output logic             out_last,
  output logic             out_ovf,
`ifdef SIMD_DRAIN_CARRY_EN
  output logic             out_carry,
`endif
  input  logic             sat_clr,
  output logic [CNT_W-1:0] sat_count,
  output logic             width_err
);

  state_t     state_q, state_d;
  logic [1:0] lane_q, lane_d;
  cap_t       cap_q;
  logic       capture, accept;

`ifndef SIMD_DRAIN_CARRY_EN
  logic unused_carry;
  assign unused_carry = ^carry_out;
`endif

  assign out_valid = (state_q == DRAIN);
  assign out_lane  = lane_q;
  assign accept    = out_valid & out_ready;

  always_comb begin
    state_d  = state_q;
    lane_d   = lane_q;
    in_ready = (state_q == IDLE) | (accept & out_last);
    capture  = in_valid & in_ready;
    if (capture) begin
      state_d = DRAIN;
      lane_d  = 2'd0;
    end else if (accept & out_last) begin
      state_d = IDLE;
      lane_d  = 2'd0;
    end else if (accept) begin
      lane_d  = lane_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lane_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
    end
  end

  // Reserved width is folded to 1x32 at capture so the mux never sees it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_q <= '0;
    end else if (capture) begin
      cap_q.result   <= result;
      cap_q.width    <= (width == WRSV) ? W32 : width;
      cap_q.saturate <= saturate;
      cap_q.overflow <= overflow;
`ifdef SIMD_DRAIN_CARRY_EN
      cap_q.carry    <= carry_out;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count <= '0;
      width_err <= 1'b0;
    end else if (sat_clr) begin
      sat_count <= '0;
      width_err <= 1'b0;
    end else begin
      if (accept & out_ovf & cap_q.saturate & (sat_count != {CNT_W{1'b1}}))
        sat_count <= sat_count + 1'b1;
      if (capture & (width == WRSV))
        width_err <= 1'b1;
    end
  end

  simd_lane_mux #(.SIGN_EXT(SIGN_EXT)) u_mux (
    .result    (cap_q.result),
    .overflow  (cap_q.overflow),
    .width     (cap_q.width),
    .lane      (lane_q),
    .lane_data (out_data),
    .lane_ovf  (out_ovf),
    .lane_last (out_last)
`ifdef SIMD_DRAIN_CARRY_EN
    ,
    .carry     (cap_q.carry),
    .lane_carry(out_carry)
`endif
  );

endmodule

// File: tb/tb_simd_lane_drain.sv
// Directed bench for simd_lane_drain (small counter width to reach saturation quickly).
module tb_simd_lane_drain;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready;
  logic [31:0]      result;
  logic [1:0]       width;
  logic             saturate;
  logic [3:0]       overflow, carry_out;
  logic             out_valid, out_ready;
  logic [31:0]      out_data;
  logic [1:0]       out_lane;
  logic             out_last, out_ovf;
`ifdef SIMD_DRAIN_CARRY_EN
  logic             out_carry;
`endif
  logic             sat_clr;
  logic [CNT_W-1:0] sat_count;
  logic             width_err;

  int cmp = 0;
  int mis = 0;

  always #5 clk = ~clk;

  simd_lane_drain #(.SIGN_EXT(1), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .result(result), .width(width), .saturate(saturate), .overflow(overflow),
    .carry_out(carry_out), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_lane(out_lane), .out_last(out_last), .out_ovf(out_ovf),
`ifdef SIMD_DRAIN_CARRY_EN
    .out_carry(out_carry),
`endif
    .sat_clr(sat_clr), .sat_count(sat_count), .width_err(width_err)
  );

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; result = '0; width = 2'b00; saturate = 1'b0;
    overflow = '0; carry_out = '0; out_ready = 1'b0; sat_clr = 1'b0;
    repeat (2) @(negedge clk);
    cmp++; if (out_valid !== 1'b0) begin mis++; $display("FAIL rst_valid got %b want 0", out_valid); end
    cmp++; if (out_lane !== 2'd0) begin mis++; $display("FAIL rst_lane got %0d want 0", out_lane); end
    cmp++; if (out_last !== 1'b0 || out_ovf !== 1'b0) begin mis++; $display("FAIL rst_last_ovf got %b%b want 00", out_last, out_ovf); end
    cmp++; if (out_data !== 32'h0) begin mis++; $display("FAIL rst_data got %h want 0", out_data); end
    cmp++; if (sat_count !== '0 || width_err !== 1'b0) begin mis++; $display("FAIL rst_cnt got %0d/%b want 0/0", sat_count, width_err); end
    rst_n = 1'b1;
    @(negedge clk);
    cmp++; if (in_ready !== 1'b1) begin mis++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_w8;
    logic [31:0] exp_d [4];
    logic [3:0]  exp_o;
    exp_d[0] = 32'hFFFFFFFF; exp_d[1] = 32'h00000001;
    exp_d[2] = 32'h0000007F; exp_d[3] = 32'hFFFFFF80;
    exp_o = 4'b1001;
    in_valid = 1'b1; result = 32'h807F01FF; width = 2'b00; saturate = 1'b1;
    overflow = 4'b1001; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cmp++;
      if (out_valid !== 1'b1 || out_lane !== 2'(i) || out_data !== exp_d[i] ||
          out_ovf !== exp_o[i] || out_last !== (i == 3)) begin
        mis++;
        $display("FAIL w8_lane%0d got v%b l%0d d%h o%b last%b want v1 l%0d d%h o%b last%b",
                 i, out_valid, out_lane, out_data, out_ovf, out_last, i, exp_d[i], exp_o[i], i == 3);
      end
      @(negedge clk);
    end
    cmp++; if (out_valid !== 1'b0 || sat_count !== 2'd2) begin mis++; $display("FAIL w8_end got v%b cnt%0d want v0 cnt2", out_valid, sat_count); end
  endtask

  task automatic test_w16;
    in_valid = 1'b1; result = 32'h80001234; width = 2'b01; saturate = 1'b1;
    overflow = 4'b1000; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    cmp++; if (out_lane !== 2'd0 || out_data !== 32'h00001234 || out_ovf !== 1'b0 || out_last !== 1'b0) begin
      mis++; $display("FAIL w16_lane0 got l%0d d%h o%b last%b want l0 d00001234 o0 last0", out_lane, out_data, out_ovf, out_last); end
    @(negedge clk);
    cmp++; if (out_lane !== 2'd1 || out_data !== 32'hFFFF8000 || out_ovf !== 1'b1 || out_last !== 1'b1) begin
      mis++; $display("FAIL w16_lane1 got l%0d d%h o%b last%b want l1 dFFFF8000 o1 last1", out_lane, out_data, out_ovf, out_last); end
    @(negedge clk);
    cmp++; if (out_valid !== 1'b0 || sat_count !== 2'd3) begin mis++; $display("FAIL w16_end got v%b cnt%0d want v0 cnt3", out_valid, sat_count); end
  endtask

  task automatic test_w32_stall;
    in_valid = 1'b1; result = 32'hDEADBEEF; width = 2'b10; saturate = 1'b0;
    overflow = 4'b0000; out_ready = 1'b0;
    @(negedge clk);
    // a competing request during the stall must be ignored
    result = 32'h0BAD0BAD; width = 2'b00;
    for (int i = 0; i < 3; i++) begin
      #1;
      cmp++;
      if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF || in_ready !== 1'b0 || out_last !== 1'b1) begin
        mis++; $display("FAIL w32_stall%0d got v%b d%h rdy%b last%b want v1 dDEADBEEF rdy0 last1", i, out_valid, out_data, in_ready, out_last); end
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    cmp++; if (out_data !== 32'hDEADBEEF || in_ready !== 1'b1) begin
      mis++; $display("FAIL w32_xfer got d%h rdy%b want dDEADBEEF rdy1", out_data, in_ready); end
    @(negedge clk);
    cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin mis++; $display("FAIL w32_end got v%b rdy%b want v0 rdy1", out_valid, in_ready); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_d [4];
    exp_d[0] = 32'h1; exp_d[1] = 32'h2; exp_d[2] = 32'h3; exp_d[3] = 32'h4;
    in_valid = 1'b1; result = 32'hAAAA5555; width = 2'b01; saturate = 1'b0;
    overflow = 4'b0000; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    cmp++; if (out_data !== 32'h00005555) begin mis++; $display("FAIL b2b_first got %h want 00005555", out_data); end
    @(negedge clk);
    in_valid = 1'b1; result = 32'h04030201; width = 2'b00;
    #1;
    cmp++; if (in_ready !== 1'b1 || out_last !== 1'b1 || out_data !== 32'hFFFFAAAA) begin
      mis++; $display("FAIL b2b_last got rdy%b last%b d%h want rdy1 last1 dFFFFAAAA", in_ready, out_last, out_data); end
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cmp++;
      if (out_valid !== 1'b1 || out_lane !== 2'(i) || out_data !== exp_d[i]) begin
        mis++; $display("FAIL b2b_second%0d got v%b l%0d d%h want v1 l%0d d%h", i, out_valid, out_lane, out_data, i, exp_d[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_wrsv_clr;
    in_valid = 1'b1; result = 32'h87654321; width = 2'b11; saturate = 1'b1;
    overflow = 4'b1000; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    cmp++; if (out_data !== 32'h87654321 || out_last !== 1'b1 || out_ovf !== 1'b1 || width_err !== 1'b1) begin
      mis++; $display("FAIL wrsv got d%h last%b o%b werr%b want d87654321 last1 o1 werr1", out_data, out_last, out_ovf, width_err); end
    sat_clr = 1'b1;
    @(negedge clk);
    sat_clr = 1'b0;
    cmp++; if (sat_count !== 2'd0 || width_err !== 1'b0 || out_valid !== 1'b0) begin
      mis++; $display("FAIL sat_clr got cnt%0d werr%b v%b want cnt0 werr0 v0", sat_count, width_err, out_valid); end
  endtask

  task automatic test_sat_hold;
    in_valid = 1'b1; result = 32'h01020304; width = 2'b00; saturate = 1'b1;
    overflow = 4'b1111; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    cmp++; if (sat_count !== 2'd3) begin mis++; $display("FAIL sat_hold got %0d want 3", sat_count); end
  endtask

  task automatic test_reset_mid;
    in_valid = 1'b1; result = 32'h44332211; width = 2'b00; saturate = 1'b1;
    overflow = 4'b1111; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    cmp++; if (out_lane !== 2'd1 || out_data !== 32'h22) begin mis++; $display("FAIL mid_lane1 got l%0d d%h want l1 d00000022", out_lane, out_data); end
    rst_n = 1'b0;
    #1;
    cmp++; if (out_valid !== 1'b0 || out_lane !== 2'd0) begin mis++; $display("FAIL mid_async got v%b l%0d want v0 l0", out_valid, out_lane); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    cmp++; if (in_ready !== 1'b1 || sat_count !== 2'd0) begin mis++; $display("FAIL mid_release got rdy%b cnt%0d want rdy1 cnt0", in_ready, sat_count); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cmp++; if (out_valid !== 1'b0) begin mis++; $display("FAIL mid_stale%0d got v%b want v0", i, out_valid); end
    end
  endtask

  initial begin
    test_reset;
    test_w8;
    test_w16;
    test_w32_stall;
    test_back_to_back;
    test_wrsv_clr;
    test_sat_hold;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end

endmodule

// File: doc/simd_lane_drain.md
Name: simd_lane_drain

Overview:
- Consumer end of the partitioned SIMD adder. Captures one 32-bit packed result and its per-byte overflow/carry flags.
- Serialises the result lane by lane over a valid/ready stream, emitting a per-lane overflow flag with each lane.
- Keeps a sticky count of saturation events.
- Sits between the adder datapath and the writeback/trace logic.

Parameters:
- SIGN_EXT, 1, 1 = sign-extend each lane to 32 bits on out_data; 0 = zero-extend.
- CNT_W, 8, width of the saturation-event counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  packed result available.
- in_ready  output  1  block can accept a packed result.
- result  input  32  packed adder result.
- width  input  2  lane width: 00 = 4x8, 01 = 2x16, 10 = 1x32, 11 = reserved.
- saturate  input  1  result was produced in saturating mode.
- overflow  input  4  per-byte-slice overflow flags.
- carry_out  input  4  per-byte-slice carry-out.
- out_valid  output  1  lane data valid.
- out_ready  input  1  downstream accepts lane.
- out_data  output  32  extended lane value.
- out_lane  output  2  lane index, 0 first.
- out_last  output  1  final lane of the current packed result.
- out_ovf  output  1  overflow flag for this lane.
- sat_clr  input  1  synchronous clear of sat_count and width_err.
- sat_count  output  CNT_W  saturating count of emitted lanes with out_ovf & saturate.
- width_err  output  1  sticky: a reserved width was captured.

Behaviour:
- Reset (async, rst_n low): state IDLE; out_valid=0; out_lane=0; out_last=0; out_ovf=0; out_data=0; sat_count=0; width_err=0; in_ready=1 once released. Asserting reset mid-drain aborts immediately; the partial result is discarded.
- States:
  - IDLE: in_ready=1.
  - DRAIN: out_valid=1.
- Capture:
  - IDLE & in_valid: register result, width, saturate, overflow and carry_out; go to DRAIN; lane index=0.
  - Latency: out_valid rises on the cycle after the capture edge.
- Lane count and mapping:
  - Width 00: 4 lanes. Lane i = result[8i+7:8i], ovf = overflow[i].
  - Width 01: 2 lanes. Lane 0 = result[15:0], ovf = overflow[1]; lane 1 = result[31:16], ovf = overflow[3].
  - Width 10: 1 lane. Lane = result, ovf = overflow[3].
  - Width 11: treated as 10; width_err set sticky at capture.
- Extension: lane value is sign- or zero-extended to 32 bits per SIGN_EXT. Width 10 passes through unchanged.
- Output handshake:
  - out_data, out_lane, out_last and out_ovf hold stable while out_valid & !out_ready.
  - Lane advances only on out_valid & out_ready.
  - out_last=1 on the highest lane index for the captured width.
- Back-to-back:
  - in_ready is also 1 in DRAIN during the cycle where out_valid & out_ready & out_last.
  - A new capture then occurs on that edge; state stays DRAIN with lane index=0. No bubble.
- Counter:
  - On each accepted lane with out_ovf & captured saturate, sat_count increments.
  - It holds at 2^CNT_W-1 and does not wrap.
  - sat_clr clears sat_count and width_err on the next edge. Clear wins over a simultaneous increment (result 0).
- in_valid while in_ready=0 is ignored. The upstream must hold its data; no input buffering beyond one entry.

Optional Feature:
- SIMD_DRAIN_CARRY_EN defined: adds output port out_carry (1 bit), valid with out_valid.
  - Mapping: width 00 lane i → carry_out[i]; width 01 lane 0 → carry_out[1], lane 1 → carry_out[3]; width 10 → carry_out[3].
  - carry_out is registered at capture.
- Undefined: port and carry register are absent; carry_out input is unused.

Decomposition:
- Package simd_pkg holds:
  - Width encodings W8=2'b00, W16=2'b01, W32=2'b10, WRSV=2'b11.
  - The lane-count function (width → 4/2/1).
  - The state enum IDLE/DRAIN.
- Sub-module simd_lane_mux (combinational): captured result/overflow/carry, width and lane index in; extended lane data, lane ovf, lane carry and last out.
- The top holds the FSM, capture registers and counter.

Test Plan:
- Width 00, result=32'h80_7F_01_FF, overflow=4'b1001, saturate=1, out_ready=1 → lanes 0..3 with out_data = FFFFFFFF, 00000001, 0000007F, FFFFFF80; ovf = 1, 0, 0, 1; out_last only on lane 3; sat_count=2.
- Width 01, result=32'h8000_1234, overflow=4'b1000, SIGN_EXT=1 → lane 0 = 00001234 with ovf=0; lane 1 = FFFF8000 with ovf=1 and out_last=1.
- Width 10 with out_ready low for 3 cycles → out_data=result held stable and in_ready=0 throughout; one transfer on out_ready; then in_ready=1.
- Back-to-back: second in_valid presented during the last lane of the first result → accepted on the same edge; next cycle shows out_lane=0 of the second result, with no idle cycle.
- Width 11 captured → treated as a single 32-bit lane; width_err=1. Then sat_clr together with an overflowing saturated lane → sat_count=0 and width_err=0.
- rst_n pulsed low during lane 1 of a width-00 drain → out_valid drops asynchronously; after release, in_ready=1, sat_count=0, and no stale lanes are emitted.
